// File: rtl/apb_regbank_if.sv
// APB4 bus bundle between the requester and the apb_regbank completer.
interface apb_regbank_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   paddr;
    logic [2:0]              pprot;
    logic                    pnse;
    logic                    psel;
    logic                    penable;
    logic                    pwrite;
    logic [DATA_WIDTH-1:0]   pwdata;
    logic [DATA_WIDTH/8-1:0] pstrb;
    logic                    pready;
    logic [DATA_WIDTH-1:0]   prdata;
    logic                    pslverr;

    modport master (
        output paddr, pprot, pnse, psel, penable, pwrite, pwdata, pstrb,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  paddr, pprot, pnse, psel, penable, pwrite, pwdata, pstrb,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/apb_regbank.sv
// APB4 completer with a word-addressed register bank: NUM_REGS-1 read-write
// control words plus one read-only status word sampled from hw_status.
module apb_regbank #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned NUM_REGS    = 8,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic                               pclk,
    input  logic                               presetn,
    apb_regbank_if.slave                       apb,
    input  logic [DATA_WIDTH-1:0]              hw_status,
    output logic [(NUM_REGS-1)*DATA_WIDTH-1:0] ctrl_regs,
    output logic [NUM_REGS-2:0]                wr_pulse
);

    localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int unsigned NBYTE = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] ADDR_LIMIT = ADDR_WIDTH'(NUM_REGS * 4);
    localparam logic [IDX_W-1:0] RO_IDX = IDX_W'(NUM_REGS - 1);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e                  state_q;
    logic [3:0]              cnt_q;
    logic [IDX_W-1:0]        idx_q;
    logic                    write_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [NBYTE-1:0]        strb_q;
    logic                    err_q;
    logic                    pready_q;
    logic                    pslverr_q;
    logic [DATA_WIDTH-1:0]   prdata_q;
    logic [NUM_REGS-2:0]     wr_pulse_q;
    logic [DATA_WIDTH-1:0]   regs_q [NUM_REGS-1];

    logic [IDX_W-1:0]        live_idx;
    logic                    live_err;
    logic [IDX_W-1:0]        rd_idx;
    logic [DATA_WIDTH-1:0]   rd_word;
    logic                    setup;
    logic                    unused_apb;

    assign unused_apb = ^{apb.pprot, apb.pnse};

    assign setup    = apb.psel & ~apb.penable;
    assign live_idx = apb.paddr[2 +: IDX_W];

    // Decode errors of the transfer currently presented on the bus.
    always_comb begin
        live_err = 1'b0;
        if (apb.paddr[1:0] != 2'b00)               live_err = 1'b1;
        if (apb.paddr >= ADDR_LIMIT)               live_err = 1'b1;
        if (apb.pwrite && (live_idx == RO_IDX))    live_err = 1'b1;
        if (!apb.pwrite && (apb.pstrb != '0))      live_err = 1'b1;
    end

    // With zero wait states read data is captured on the setup edge, so it
    // must come from the live address; otherwise from the latched index.
    assign rd_idx = (state_q == StIdle) ? live_idx : idx_q;

    // Read mux over the RW registers and the RO status word.
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < int'(NUM_REGS) - 1; i++) begin
            if (rd_idx == IDX_W'(i)) rd_word = regs_q[i];
        end
        if (rd_idx == RO_IDX) rd_word = hw_status;
    end

    // Transfer FSM with registered response outputs and write commit.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            idx_q      <= '0;
            write_q    <= 1'b0;
            wdata_q    <= '0;
            strb_q     <= '0;
            err_q      <= 1'b0;
            pready_q   <= 1'b0;
            pslverr_q  <= 1'b0;
            prdata_q   <= '0;
            wr_pulse_q <= '0;
            for (int i = 0; i < int'(NUM_REGS) - 1; i++) regs_q[i] <= '0;
        end else begin
            wr_pulse_q <= '0;
            unique case (state_q)
                StIdle: begin
                    if (setup) begin
                        idx_q   <= live_idx;
                        write_q <= apb.pwrite;
                        wdata_q <= apb.pwdata;
                        strb_q  <= apb.pstrb;
                        err_q   <= live_err;
                        cnt_q   <= 4'(WAIT_CYCLES);
                        if (WAIT_CYCLES == 0) begin
                            state_q   <= StResp;
                            pready_q  <= 1'b1;
                            pslverr_q <= live_err;
                            prdata_q  <= (!apb.pwrite && !live_err) ? rd_word : '0;
                        end else begin
                            state_q <= StWait;
                        end
                    end
                end
                StWait: begin
                    if (!apb.psel) begin
                        state_q   <= StIdle;
                        pready_q  <= 1'b0;
                        pslverr_q <= 1'b0;
                        prdata_q  <= '0;
                    end else if (apb.penable) begin
                        if (cnt_q <= 4'd1) begin
                            state_q   <= StResp;
                            pready_q  <= 1'b1;
                            pslverr_q <= err_q;
                            prdata_q  <= (!write_q && !err_q) ? rd_word : '0;
                        end else begin
                            cnt_q <= cnt_q - 4'd1;
                        end
                    end
                end
                StResp: begin
                    if (!apb.psel) begin
                        state_q   <= StIdle;
                        pready_q  <= 1'b0;
                        pslverr_q <= 1'b0;
                        prdata_q  <= '0;
                    end else if (apb.penable) begin
                        // Completing edge: commit only error-free writes.
                        if (write_q && !err_q) begin
                            for (int i = 0; i < int'(NUM_REGS) - 1; i++) begin
                                if (idx_q == IDX_W'(i)) begin
                                    wr_pulse_q[i] <= 1'b1;
                                    for (int b = 0; b < int'(NBYTE); b++) begin
                                        if (strb_q[b]) regs_q[i][b*8 +: 8] <= wdata_q[b*8 +: 8];
                                    end
                                end
                            end
                        end
                        state_q   <= StIdle;
                        pready_q  <= 1'b0;
                        pslverr_q <= 1'b0;
                        prdata_q  <= '0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign apb.pready  = pready_q;
    assign apb.pslverr = pslverr_q;
    assign apb.prdata  = prdata_q;
    assign wr_pulse    = wr_pulse_q;

    for (genvar i = 0; i < int'(NUM_REGS) - 1; i++) begin : g_ctrl
        assign ctrl_regs[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
    end

endmodule

// File: doc/apb_regbank.md
# apb_regbank

APB4 completer that terminates transfers from the team's APB requester and exposes a small word-addressed register bank to local hardware. It accepts SETUP/ACCESS transfers and inserts a configurable number of wait states. Writes honour byte strobes, and decode/protocol errors are flagged on pslverr. Read-write control registers drive the local logic, and one read-only status word samples a hardware input.

## Interface
Parameters:
- ADDR_WIDTH, 32, APB address width
- DATA_WIDTH, 32, APB data width; multiple of 8
- NUM_REGS, 8, register count (≥2); indices 0..NUM_REGS-2 RW, index NUM_REGS-1 RO status
- WAIT_CYCLES, 0, wait states inserted before pready (0..15)

Ports:
- Clocking and reset (already decided): reset presetn, asynchronous, active-low; clock pclk.
- pclk  in  1  clock
- presetn  in  1  async active-low reset
- paddr  in  ADDR_WIDTH  byte address
- pprot  in  3  ignored
- pnse  in  1  ignored
- psel  in  1  select
- penable  in  1  access phase
- pwrite  in  1  1=write
- pwdata  in  DATA_WIDTH  write data
- pstrb  in  DATA_WIDTH/8  byte strobes
- pready  out  1  transfer complete, registered
- prdata  out  DATA_WIDTH  read data, registered
- pslverr  out  1  error, valid only with pready
- hw_status  in  DATA_WIDTH  value returned by the RO register
- ctrl_regs  out  (NUM_REGS-1)*DATA_WIDTH  RW registers, reg i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- wr_pulse  out  NUM_REGS-1  one-cycle pulse per RW register on committed write

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: a setup phase (psel & ~penable) latches addr, pwrite, pwdata, pstrb and the error decode, and loads cnt=WAIT_CYCLES.
  - If WAIT_CYCLES==0: go to RESP and set pready=1 on the same edge.
  - Otherwise: go to WAIT.
- WAIT: cnt decrements each cycle while psel&penable. When cnt reaches 1, set pready=1 and go to RESP.
- RESP: pready is high. On psel&penable the transfer completes; at that edge pready, pslverr and prdata clear to 0, and the FSM returns to IDLE.
- Index = paddr[2 +: clog2(NUM_REGS)] (word-addressed; DATA_WIDTH=32 addressing).
- Error when any of the following holds (error transfers cause no state change):
  - paddr[1:0]≠0
  - paddr ≥ NUM_REGS*4
  - write to the RO index
  - read with pstrb≠0
- Write commit happens at the completing edge: for each byte b with pstrb[b]=1, ctrl_regs byte b is updated. wr_pulse[idx] is high for the following cycle. A write with pstrb=0 commits nothing but still pulses.
- Read: prdata is loaded with the register (or hw_status sampled that cycle) at the same edge pready rises. prdata=0 on writes and on errors.
- Abort: psel low while in WAIT/RESP returns to IDLE with no commit, and pready clears.
- Unexpected penable in IDLE is ignored.

## Timing
- Reset values: pready=0, prdata=0, pslverr=0, ctrl_regs=0, wr_pulse=0; FSM in IDLE.
- Reset asserted mid-transfer forces all reset values immediately; no partial commit.
- Latency: pready is high in access cycle 1+WAIT_CYCLES after setup. With WAIT_CYCLES=0 there is zero wait and pready is high in the first access cycle.
- Transfer occupies 2+WAIT_CYCLES cycles.
- Back-to-back: a new setup phase is accepted in the cycle immediately after completion.
- ctrl_regs reflects a write one cycle after the completing edge, the same cycle wr_pulse is high.
- pslverr is never high without pready.

## Test plan
- Write then read, WAIT_CYCLES=0: write 0xDEADBEEF to 0x04 with pstrb=0xF → pready in cycle 2, pslverr=0, wr_pulse[1] pulses once. Read 0x04 → prdata=0xDEADBEEF.
- Strobes: reg2=0x11223344, write 0xAABBCCDD with pstrb=0x5 → reg2=0x11BB33DD.
- Wait states, WAIT_CYCLES=3: read 0x00 → pready low for 3 access cycles and high on the 4th. Total transfer = 5 cycles.
- Errors, each → pslverr=1 with pready and registers unchanged:
  - write to RO index 0x1C
  - paddr=0x20
  - paddr=0x06
  - read with pstrb=0x1
- RO read: hw_status=0x0000CAFE, read 0x1C → prdata=0x0000CAFE, pslverr=0.
- Disturbance: pulse presetn low during WAIT of a write → outputs 0, reg unchanged, and the next transfer completes normally. Drop psel in RESP → no commit, FSM back to IDLE.
